// File: rtl/piano_pkg.sv
// Shared types and constants for the piano auto-play engine.
// Build option: AUTO_PLAY_LOOP_EN (song loops forever instead of stopping).
package piano_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int NOTE_REST  = 0;
  localparam int NOTE_W_DEF = 4;
  localparam int DUR_W_DEF  = 26;

endpackage

// File: rtl/auto_play_sequencer_if.sv
// Song memory read bus between the sequencer and the song store.
// Build option: AUTO_PLAY_LOOP_EN (no effect on this bus).
interface auto_play_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 26
);

  logic [ADDR_W-1:0] mem_addr;
  logic [NOTE_W-1:0] mem_note;
  logic [DUR_W-1:0]  mem_duration;
  logic              mem_valid;

  modport master (
    output mem_addr,
    input  mem_note,
    input  mem_duration,
    input  mem_valid
  );

  modport slave (
    input  mem_addr,
    output mem_note,
    output mem_duration,
    output mem_valid
  );

endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero and only moves when enabled.
// Build option: AUTO_PLAY_LOOP_EN (no effect here).
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/auto_play_sequencer.sv
// Auto-play engine: walks song memory and drives the buzzer key.
// Build option: AUTO_PLAY_LOOP_EN makes every song end restart the pass.
module auto_play_sequencer
  import piano_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int DUR_W      = DUR_W_DEF,
  parameter int GAP_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              confirm_pulse,
  input  logic              pause_pulse,
  input  logic [ADDR_W-1:0] song_base,
  auto_play_sequencer_if.master mem,
  output logic              key_on,
  output logic [NOTE_W-1:0] key,
  output logic              playing,
  output logic              paused,
  output logic              song_done,
  output logic [ADDR_W-1:0] note_index
);

  localparam int GAP_W =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LD =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(NOTE_REST);

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;

  logic             dur_load;
  logic             dur_en;
  logic             dur_zero;
  logic [DUR_W-1:0] dur_ld_val;
  logic             gap_load;
  logic             gap_en;
  logic             gap_zero;

  logic play_end;
  logic gap_end;
  logic adv;
  logic at_last;
  logic song_end;

  assign mem.mem_addr = addr_q;
  assign note_index   = addr_q - base_q;

  // a zero duration still sounds for one cycle
  assign dur_ld_val = (mem.mem_duration == '0) ? '0
                    : mem.mem_duration - DUR_W'(1);

  assign play_end = (state == ST_PLAY) && !paused && dur_zero;
  assign gap_end  = (state == ST_GAP) && !paused && gap_zero;
  assign adv      = (play_end && !HAS_GAP) || gap_end;
  assign at_last  = (addr_q == '1);
  assign song_end = ((state == ST_LOAD) && !mem.mem_valid)
                 || (adv && at_last);

  assign dur_load = (state == ST_LOAD) && mem.mem_valid;
  assign dur_en   = (state == ST_PLAY) && !paused;
  assign gap_load = play_end && HAS_GAP;
  assign gap_en   = (state == ST_GAP) && !paused;

  seq_down_counter #(.W(DUR_W)) u_dur (
    .clk      (clk),
    .rst      (rst),
    .load     (dur_load),
    .load_val (dur_ld_val),
    .en       (dur_en),
    .zero     (dur_zero)
  );

  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LD),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      key       <= '0;
      key_on    <= 1'b0;
      playing   <= 1'b0;
      paused    <= 1'b0;
      song_done <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (confirm_pulse) begin
        addr_q  <= song_base;
        base_q  <= song_base;
        paused  <= 1'b0;
        key_on  <= 1'b0;
        playing <= 1'b1;
        state   <= ST_FETCH;
      end else begin
        unique case (state)
          ST_FETCH: state <= ST_LOAD;
          ST_LOAD: begin
            if (mem.mem_valid) begin
              key    <= mem.mem_note;
              key_on <= (mem.mem_note != REST);
              state  <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (pause_pulse) begin
              paused <= !paused;
              key_on <= paused && (key != REST);
            end
            if (play_end) begin
              key_on <= 1'b0;
              state  <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (pause_pulse) begin
              paused <= !paused;
            end
          end
          default: ;
        endcase
        // end-of-pass and advance take priority over the case above
        if (song_end) begin
          song_done <= 1'b1;
          key_on    <= 1'b0;
          paused    <= 1'b0;
`ifdef AUTO_PLAY_LOOP_EN
          addr_q    <= base_q;
          state     <= ST_FETCH;
`else
          playing   <= 1'b0;
          state     <= ST_DONE;
`endif
        end else if (adv) begin
          addr_q <= addr_q + ADDR_W'(1);
          paused <= 1'b0;
          state  <= ST_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_auto_play_sequencer.sv
// Directed bench: three sequencer builds (gap 2, gap 0, 2-bit address).
// Build option: AUTO_PLAY_LOOP_EN switches the address-end expectations.
module tb_auto_play_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  // ---- DUT A: ADDR_W=5, GAP_CYCLES=2
  auto_play_sequencer_if #(.ADDR_W(5), .NOTE_W(4), .DUR_W(26)) ifa ();
  logic       conf_a = 0, pause_a = 0;
  logic [4:0] base_a = '0;
  logic       ka_on, pl_a, pa_a, sd_a;
  logic [3:0] ka_key;
  logic [4:0] ni_a;
  logic [3:0]  na [32];
  logic [25:0] da [32];
  logic        va [32];

  auto_play_sequencer #(.ADDR_W(5), .NOTE_W(4), .DUR_W(26),
    .GAP_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .confirm_pulse(conf_a),
    .pause_pulse(pause_a), .song_base(base_a), .mem(ifa),
    .key_on(ka_on), .key(ka_key), .playing(pl_a),
    .paused(pa_a), .song_done(sd_a), .note_index(ni_a));

  always @(posedge clk) begin
    ifa.mem_note     <= na[ifa.mem_addr];
    ifa.mem_duration <= da[ifa.mem_addr];
    ifa.mem_valid    <= va[ifa.mem_addr];
  end

  // ---- DUT B: ADDR_W=5, GAP_CYCLES=0
  auto_play_sequencer_if #(.ADDR_W(5), .NOTE_W(4), .DUR_W(26)) ifb ();
  logic       conf_b = 0, pause_b = 0;
  logic [4:0] base_b = '0;
  logic       kb_on, pl_b, pa_b, sd_b;
  logic [3:0] kb_key;
  logic [4:0] ni_b;
  logic [3:0]  nb [32];
  logic [25:0] db [32];
  logic        vb [32];

  auto_play_sequencer #(.ADDR_W(5), .NOTE_W(4), .DUR_W(26),
    .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .confirm_pulse(conf_b),
    .pause_pulse(pause_b), .song_base(base_b), .mem(ifb),
    .key_on(kb_on), .key(kb_key), .playing(pl_b),
    .paused(pa_b), .song_done(sd_b), .note_index(ni_b));

  always @(posedge clk) begin
    ifb.mem_note     <= nb[ifb.mem_addr];
    ifb.mem_duration <= db[ifb.mem_addr];
    ifb.mem_valid    <= vb[ifb.mem_addr];
  end

  // ---- DUT C: ADDR_W=2, GAP_CYCLES=2
  auto_play_sequencer_if #(.ADDR_W(2), .NOTE_W(4), .DUR_W(26)) ifc ();
  logic       conf_c = 0, pause_c = 0;
  logic [1:0] base_c = '0;
  logic       kc_on, pl_c, pa_c, sd_c;
  logic [3:0] kc_key;
  logic [1:0] ni_c;
  logic [3:0]  nc [4];
  logic [25:0] dc [4];
  logic        vc [4];

  auto_play_sequencer #(.ADDR_W(2), .NOTE_W(4), .DUR_W(26),
    .GAP_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .confirm_pulse(conf_c),
    .pause_pulse(pause_c), .song_base(base_c), .mem(ifc),
    .key_on(kc_on), .key(kc_key), .playing(pl_c),
    .paused(pa_c), .song_done(sd_c), .note_index(ni_c));

  always @(posedge clk) begin
    ifc.mem_note     <= nc[ifc.mem_addr];
    ifc.mem_duration <= dc[ifc.mem_addr];
    ifc.mem_valid    <= vc[ifc.mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    vec++;
    if (ka_on !== 1'b0 || ka_key !== 4'd0) begin
      errs++;
      $display("FAIL reset_key got on=%b key=%0d exp 0/0", ka_on, ka_key);
    end
    vec++;
    if (ifa.mem_addr !== 5'd0 || ni_a !== 5'd0) begin
      errs++;
      $display("FAIL reset_addr got %0d exp 0", ifa.mem_addr);
    end
    vec++;
    if (pl_a !== 1'b0 || pa_a !== 1'b0 || sd_a !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags got %b%b%b exp 000", pl_a, pa_a, sd_a);
    end
    vec++;
    if (kb_on !== 1'b0 || kc_on !== 1'b0 || ifc.mem_addr !== 2'd0) begin
      errs++;
      $display("FAIL reset_bc got %b %b %0d exp 0 0 0",
               kb_on, kc_on, ifc.mem_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_note();
    int hi = 0, first = -1, done_at = -1, dn = 0;
    na[3] = 4'd5; da[3] = 26'd10; va[3] = 1'b1; va[4] = 1'b0;
    conf_a = 1; pause_a = 1; base_a = 5'd3;
    step();
    conf_a = 0; pause_a = 0;
    vec++;
    if (ifa.mem_addr !== 5'd3 || pa_a !== 1'b0 || pl_a !== 1'b1) begin
      errs++;
      $display("FAIL start_state got addr=%0d paused=%b playing=%b exp 3/0/1",
               ifa.mem_addr, pa_a, pl_a);
    end
    for (int e = 1; e <= 20; e++) begin
      step();
      if (ka_on && ka_key == 4'd5) begin
        hi++;
        if (first < 0) first = e;
      end
      if (sd_a) begin
        dn++;
        done_at = e;
      end
      if (e == 14) begin
        vec++;
        if (ni_a !== 5'd1) begin
          errs++;
          $display("FAIL note_index got %0d exp 1", ni_a);
        end
      end
    end
    vec++;
    if (first != 2 || hi != 10) begin
      errs++;
      $display("FAIL single_note got first=%0d high=%0d exp 2/10", first, hi);
    end
    vec++;
    if (dn != 1 || done_at != 16) begin
      errs++;
      $display("FAIL single_done got n=%0d at=%0d exp 1/16", dn, done_at);
    end
    vec++;
    if (pl_a !== 1'b0 || ka_on !== 1'b0 || ka_key !== 4'd5) begin
      errs++;
      $display("FAIL done_state got pl=%b on=%b key=%0d exp 0/0/5",
               pl_a, ka_on, ka_key);
    end
  endtask

  task automatic test_rest_zero();
    int rest_ok = 0, hi = 0, on_at = -1, done_at = -1;
    nb[0] = 4'd0; db[0] = 26'd4; vb[0] = 1'b1;
    nb[1] = 4'd7; db[1] = 26'd0; vb[1] = 1'b1;
    vb[2] = 1'b0;
    conf_b = 1; base_b = 5'd0;
    step();
    conf_b = 0;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e >= 2 && e <= 5 && pl_b && !kb_on && kb_key == 4'd0)
        rest_ok++;
      if (kb_on) begin
        hi++;
        if (kb_key == 4'd7) on_at = e;
      end
      if (sd_b) done_at = e;
    end
    vec++;
    if (rest_ok != 4) begin
      errs++;
      $display("FAIL rest_cycles got %0d exp 4", rest_ok);
    end
    vec++;
    if (hi != 1 || on_at != 8) begin
      errs++;
      $display("FAIL zero_dur got high=%0d at=%0d exp 1/8", hi, on_at);
    end
    vec++;
    if (done_at != 11 || pl_b !== 1'b0) begin
      errs++;
      $display("FAIL rest_done got at=%0d pl=%b exp 11/0", done_at, pl_b);
    end
  endtask

  task automatic test_pause();
    int hi = 0, bad = 0, done_at = -1;
    na[8] = 4'd3; da[8] = 26'd20; va[8] = 1'b1; va[9] = 1'b0;
    conf_a = 1; base_a = 5'd8;
    step();
    conf_a = 0;
    for (int e = 1; e <= 70; e++) begin
      pause_a = (e == 7 || e == 37);
      step();
      pause_a = 0;
      if (ka_on) hi++;
      if (e >= 7 && e <= 36)
        if (ka_on || !pa_a || ifa.mem_addr != 5'd8) bad++;
      if (sd_a && done_at < 0) done_at = e;
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL pause_hold got %0d bad cycles exp 0", bad);
    end
    vec++;
    if (hi != 20) begin
      errs++;
      $display("FAIL pause_high got %0d exp 20", hi);
    end
    vec++;
    if (done_at != 56 || pa_a !== 1'b0) begin
      errs++;
      $display("FAIL pause_done got at=%0d paused=%b exp 56/0",
               done_at, pa_a);
    end
  endtask

  task automatic test_restart();
    int dn = 0, done_at = -1;
    na[10] = 4'd9; da[10] = 26'd3; va[10] = 1'b1; va[11] = 1'b0;
    conf_a = 1; base_a = 5'd3;
    step();
    conf_a = 0;
    repeat (12) step();
    vec++;
    if (ka_on !== 1'b0 || pl_a !== 1'b1) begin
      errs++;
      $display("FAIL in_gap got on=%b pl=%b exp 0/1", ka_on, pl_a);
    end
    conf_a = 1; base_a = 5'd10;
    step();
    conf_a = 0;
    if (sd_a) dn++;
    vec++;
    if (ifa.mem_addr !== 5'd10 || ka_on !== 1'b0 || ni_a !== 5'd0) begin
      errs++;
      $display("FAIL restart_addr got %0d on=%b exp 10/0",
               ifa.mem_addr, ka_on);
    end
    step();
    if (sd_a) dn++;
    step();
    if (sd_a) dn++;
    vec++;
    if (ka_on !== 1'b1 || ka_key !== 4'd9 || dn != 0) begin
      errs++;
      $display("FAIL restart_note got on=%b key=%0d done=%0d exp 1/9/0",
               ka_on, ka_key, dn);
    end
    for (int e = 16; e <= 30; e++) begin
      step();
      if (sd_a && done_at < 0) done_at = e;
    end
    vec++;
    if (done_at != 22) begin
      errs++;
      $display("FAIL restart_done got %0d exp 22", done_at);
    end
  endtask

  task automatic test_addr_end();
    logic [3:0] notes [8];
    int n = 0, dn = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nc[i] = 4'(i + 1); dc[i] = 26'd2; vc[i] = 1'b1;
    end
    conf_c = 1; base_c = 2'd2;
    step();
    conf_c = 0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (kc_on && !prev && n < 8) begin
        notes[n] = kc_key;
        n++;
      end
      prev = kc_on;
      if (sd_c) dn++;
    end
`ifdef AUTO_PLAY_LOOP_EN
    vec++;
    if (n < 4 || notes[0] != 4'd3 || notes[1] != 4'd4
        || notes[2] != 4'd3 || notes[3] != 4'd4) begin
      errs++;
      $display("FAIL loop_notes got n=%0d %0d %0d %0d %0d exp 3 4 3 4",
               n, notes[0], notes[1], notes[2], notes[3]);
    end
    vec++;
    if (dn != 3 || pl_c !== 1'b1) begin
      errs++;
      $display("FAIL loop_done got %0d pl=%b exp 3/1", dn, pl_c);
    end
`else
    vec++;
    if (n != 2 || notes[0] != 4'd3 || notes[1] != 4'd4) begin
      errs++;
      $display("FAIL end_notes got n=%0d %0d %0d exp 2: 3 4",
               n, notes[0], notes[1]);
    end
    vec++;
    if (dn != 1 || pl_c !== 1'b0 || ifc.mem_addr !== 2'd3) begin
      errs++;
      $display("FAIL end_nowrap got done=%0d pl=%b addr=%0d exp 1/0/3",
               dn, pl_c, ifc.mem_addr);
    end
`endif
  endtask

  task automatic test_async_reset();
    conf_a = 1; base_a = 5'd3;
    step();
    conf_a = 0;
    repeat (5) step();
    vec++;
    if (ka_on !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset got on=%b exp 1", ka_on);
    end
    #3;
    rst = 1'b1;
    #1;
    vec++;
    if (ka_on !== 1'b0 || ifa.mem_addr !== 5'd0
        || pl_a !== 1'b0 || ka_key !== 4'd0) begin
      errs++;
      $display("FAIL async_reset got on=%b addr=%0d pl=%b key=%0d exp 0",
               ka_on, ifa.mem_addr, pl_a, ka_key);
    end
    #2;
    rst = 1'b0;
    step();
    vec++;
    if (pl_a !== 1'b0 || ka_on !== 1'b0) begin
      errs++;
      $display("FAIL post_reset got pl=%b on=%b exp 0/0", pl_a, ka_on);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      na[i] = '0; da[i] = '0; va[i] = 1'b0;
      nb[i] = '0; db[i] = '0; vb[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      nc[i] = '0; dc[i] = '0; vc[i] = 1'b0;
    end
    test_reset();
    test_single_note();
    test_rest_zero();
    test_pause();
    test_restart();
    test_addr_end();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
